// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell and a carry flip-flop add
// LSB-first, one bit per clock, behind a start/busy/done handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
  output logic             done
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_next;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
  assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      S      <= '0;
      Cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= Cin;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= fa_c;
          if (count == LAST) begin
            S     <= sum_next;
            Cout  <= fa_c;
            state <= FIN;
          end else begin
            count <= count + 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder against an arithmetic
// reference ({Cout,S} = A + B + Cin) plus handshake timing expectations.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic [W-1:0] S;
  logic         Cout;
  logic         busy;
  logic         done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [W-1:0] last_s;
  logic         last_c;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .S     (S),
    .Cout  (Cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for done, bounded; returns number of edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] ref_sum;
    int n;
    int d0;
    ref_sum = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    d0 = done_cnt;
    A = a; B = b; Cin = c; start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("s_hold_in_run", {Cout, S}, {last_c, last_s});
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    wait_done(n);
    check("latency", n, W);
    check("sum", S, ref_sum[W-1:0]);
    check("cout", Cout, ref_sum[W]);
    check("busy_in_done", busy, 0);
    step();
    check("done_one_cycle", done, 0);
    check("done_pulses", done_cnt - d0, 1);
    last_s = ref_sum[W-1:0];
    last_c = ref_sum[W];
  endtask

  initial begin
    int n;
    int d0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W-1:0] opa [3];
    logic [W-1:0] opb [3];
    logic         opc [3];
    logic [W:0]   r;

    reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    step(); step();
    check("rst_S", S, 0);
    check("rst_Cout", Cout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    last_s = '0; last_c = 1'b0;
    step();

    run_op(8'h5A, 8'h33, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h00, 8'h00, 1'b0);

    // Start pulsed mid-run is ignored.
    d0 = done_cnt;
    A = 8'h5A; B = 8'h33; Cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    A = 8'h01; B = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    check("ign_latency", n, W - 3);
    check("ign_sum", S, 8'h8D);
    check("ign_cout", Cout, 0);
    step();
    repeat (12) step();
    check("ign_done_pulses", done_cnt - d0, 1);
    check("ign_busy_idle", busy, 0);
    last_s = 8'h8D; last_c = 1'b0;

    // Reset mid-run aborts the operation.
    A = 8'hFF; B = 8'h01; Cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_S", S, 0);
    check("abort_Cout", Cout, 0);
    d0 = done_cnt;
    repeat (15) step();
    check("abort_no_done", done_cnt - d0, 0);
    last_s = '0; last_c = 1'b0;
    run_op(8'h10, 8'h20, 1'b0);

    // Start held high: back-to-back operations, one per W+2 cycles.
    opa[0] = 8'h12; opb[0] = 8'h34; opc[0] = 1'b1;
    opa[1] = 8'hF0; opb[1] = 8'h0F; opc[1] = 1'b1;
    opa[2] = 8'h80; opb[2] = 8'h80; opc[2] = 1'b0;
    A = opa[0]; B = opb[0]; Cin = opc[0]; start = 1'b1;
    step();
    wait_done(n);
    check("held_first_latency", n, W);
    r = (W+1)'(opa[0]) + (W+1)'(opb[0]) + (W+1)'(opc[0]);
    check("held_sum0", {Cout, S}, r);
    for (int j = 1; j < 3; j++) begin
      A = opa[j]; B = opb[j]; Cin = opc[j];
      n = 0;
      do begin
        step();
        n++;
      end while (done !== 1'b1 && n < 40);
      check("held_spacing", n, W + 2);
      r = (W+1)'(opa[j]) + (W+1)'(opb[j]) + (W+1)'(opc[j]);
      check("held_sum", {Cout, S}, r);
      last_s = r[W-1:0]; last_c = r[W];
    end
    start = 1'b0;
    step(); step();

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
